// File: rtl/fir_frame_buffer_pkg.sv
// Shared defaults and state encodings for the FIR receive-side frame buffer.
// The bank and write-FSM encodings are plain constants so legacy code can reuse them.
package fir_frame_buffer_pkg;

  localparam int FRAME_LEN_DEF  = 16;
  localparam int IN_W_DEF       = 32;
  localparam int OUT_W_DEF      = 16;
  localparam int FRAC_SHIFT_DEF = 16;

  localparam logic [1:0] BANK_EMPTY   = 2'b00;
  localparam logic [1:0] BANK_FILLING = 2'b01;
  localparam logic [1:0] BANK_FULL    = 2'b10;

  localparam logic [0:0] WR_FILL = 1'b0;
  localparam logic [0:0] WR_DROP = 1'b1;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up a signed fixed-point value by FRAC_SHIFT bits, then saturate to OUT_W.
// The extra guard bit on the sum keeps the rounding increment from wrapping the maximum input.
module fir_round_sat
  import fir_frame_buffer_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o
);

  localparam logic signed [IN_W:0] RND =
    {{(IN_W+1-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;

  always_comb begin
    sum     = $signed({din_i[IN_W-1], din_i}) + RND;
    shifted = sum >>> FRAC_SHIFT;
    if (shifted > SAT_MAX) begin
      dout_o = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      dout_o = SAT_MIN[OUT_W-1:0];
    end else begin
      dout_o = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_frame_buffer.sv
// Packs rounded FIR samples into FRAME_LEN-sample frames held in a two-bank ping-pong buffer.
// The FIR is never stalled: when both banks are full, incoming samples are dropped and counted.
module fir_frame_buffer
  import fir_frame_buffer_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            fir_d,
  input  logic                       fir_valid,
  input  logic                       frame_ready,
  output logic [FRAME_LEN*OUT_W-1:0] frame_data,
  output logic                       frame_valid,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int               PTR_W    = $clog2(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

  logic [OUT_W-1:0] sample;
  logic [OUT_W-1:0] mem_q [2][FRAME_LEN];

  logic [1:0][1:0]  bank_st_q, bank_st_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [0:0]       wr_st_q, wr_st_d;
  logic             frame_valid_q, frame_valid_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             accept;
  logic             other_freed;
  logic             do_write;

  fir_round_sat #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .din_i  (fir_d),
    .dout_o (sample)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    bank_st_d  = bank_st_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_ptr_d   = wr_ptr_q;
    wr_st_d    = wr_st_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    do_write   = 1'b0;

    accept      = frame_valid_q && frame_ready;
    other_freed = accept && (rd_bank_q != wr_bank_q);

    if (accept) begin
      bank_st_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d            = ~rd_bank_q;
    end

    case (wr_st_q)
      WR_FILL: begin
        if (fir_valid) begin
          do_write = 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            bank_st_d[wr_bank_q] = BANK_FULL;
            wr_ptr_d             = '0;
            if (bank_st_q[~wr_bank_q] == BANK_EMPTY || other_freed) begin
              wr_bank_d = ~wr_bank_q;
            end else begin
              wr_st_d = WR_DROP;
            end
          end else begin
            bank_st_d[wr_bank_q] = BANK_FILLING;
            wr_ptr_d             = wr_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        // A sample arriving in the freeing cycle is still dropped; the next one starts the frame.
        if (fir_valid) begin
          overflow_d = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (other_freed) begin
          wr_bank_d = ~wr_bank_q;
          wr_st_d   = WR_FILL;
        end
      end
    endcase

    frame_valid_d = (bank_st_d[rd_bank_d] == BANK_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st_q     <= {BANK_EMPTY, BANK_EMPTY};
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      wr_st_q       <= WR_FILL;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      bank_st_q     <= bank_st_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_st_q       <= wr_st_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // NOTE: sample storage is deliberately not reset; frame_data is gated by frame_valid instead.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_bank_q][wr_ptr_q] <= sample;
  end

  always_comb begin
    frame_data = '0;
    if (frame_valid_q) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        frame_data[k*OUT_W +: OUT_W] = mem_q[rd_bank_q][k];
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
